fetch_sequencer: RTL and testbench

// - Stage sequencer and program-counter owner for the multicycle RV32IMF core.
// - Sole consumer of branch_enable from the branch unit, which evaluates its condition in stage 2.
// - Issues instruction fetches with a ready handshake and steps the shared 2-bit stage counter.
// - Commits the next PC in writeback: sequential (+4) or redirected; counts taken redirects.

---
 rtl/fetch_sequencer_if.sv | 28 ++
 rtl/fetch_sequencer.sv | 108 ++++++++++
 tb/tb_fetch_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch/redirect bus between the stage sequencer and the rest of the core.
// master: the sequencer (drives stage, pc, fetch request, counters).
// slave : instruction memory, branch unit and observers.
interface fetch_sequencer_if #(
  parameter int COUNT_W = 16
);
  logic               imem_ready;
  logic               branch_enable;
  logic               jump_enable;
  logic [31:0]        redirect_addr;
  logic [1:0]         stage;
  logic [31:0]        pc;
  logic               imem_req;
  logic [31:0]        imem_addr;
  logic               instr_valid;
  logic [COUNT_W-1:0] taken_count;
  logic               misaligned;

  modport master (
    input  imem_ready, branch_enable, jump_enable, redirect_addr,
    output stage, pc, imem_req, imem_addr, instr_valid, taken_count, misaligned
  );

  modport slave (
    output imem_ready, branch_enable, jump_enable, redirect_addr,
    input  stage, pc, imem_req, imem_addr, instr_valid, taken_count, misaligned
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: 4-stage sequencer and PC owner for the multicycle core.
// FETCH waits for imem_ready, then DECODE/EXECUTE/WRITEBACK run one cycle each.
// WRITEBACK commits pc (+4 or redirect) and counts redirects (saturating).
// Optional feature macro: MISALIGN_TRAP_EN -- a redirect to a non word-aligned
// target loads TRAP_VECTOR and pulses misaligned in the following FETCH cycle.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100,
  parameter int          COUNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } stage_e;

  stage_e             stage_q;
  logic [31:0]        pc_q;
  logic               instr_valid_q;
  logic [COUNT_W-1:0] cnt_q;

  logic               redirect;
  logic [31:0]        pc_d;
  logic [COUNT_W-1:0] cnt_d;
  logic               trap_d;

  assign redirect = bus.branch_enable | bus.jump_enable;

  // Next-PC and counter values, consumed only when leaving WRITEBACK.
  always_comb begin
    pc_d   = pc_q + 32'd4;
    cnt_d  = cnt_q;
    trap_d = 1'b0;
    if (redirect) begin
`ifdef MISALIGN_TRAP_EN
      trap_d = (bus.redirect_addr[1:0] != 2'b00);
      pc_d   = trap_d ? TRAP_VECTOR : bus.redirect_addr;
`else
      pc_d   = {bus.redirect_addr[31:2], 2'b00};
`endif
      // Saturate at all-ones rather than wrapping.
      if (cnt_q != {COUNT_W{1'b1}})
        cnt_d = cnt_q + {{(COUNT_W-1){1'b0}}, 1'b1};
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misaligned_q;

  // Trap pulse lands in the first FETCH cycle after the faulting redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      misaligned_q <= 1'b0;
    else
      misaligned_q <= (stage_q == S_WB) && trap_d;
  end

  assign bus.misaligned = misaligned_q;
`else
  // The low target bits and the trap vector have no use without the trap.
  logic unused_trap;
  assign unused_trap    = ^{bus.redirect_addr[1:0], TRAP_VECTOR, trap_d};
  assign bus.misaligned = 1'b0;
`endif

  // Stage FSM with PC commit and redirect counting in WRITEBACK.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      instr_valid_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      instr_valid_q <= 1'b0;
      case (stage_q)
        S_FETCH: begin
          if (bus.imem_ready) begin
            stage_q       <= S_DECODE;
            instr_valid_q <= 1'b1;
          end
        end
        S_DECODE: stage_q <= S_EXEC;
        S_EXEC:   stage_q <= S_WB;
        S_WB: begin
          stage_q <= S_FETCH;
          pc_q    <= pc_d;
          cnt_q   <= cnt_d;
        end
        default: stage_q <= S_FETCH;
      endcase
    end
  end

  // Outputs are straight decodes of registers, so they cannot glitch.
  assign bus.stage       = stage_q;
  assign bus.pc          = pc_q;
  assign bus.imem_req    = (stage_q == S_FETCH);
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.taken_count = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: an instruction-level reference model (PC, redirect
// count, pending trap) predicts every cycle of each instruction. Two DUTs share
// stimulus: default counter width and a 2-bit counter for saturation.
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  fetch_sequencer_if #(.COUNT_W(16)) ia ();
  fetch_sequencer_if #(.COUNT_W(2))  ib ();

  fetch_sequencer #(.COUNT_W(16)) dut_a (.clk(clk), .reset(reset), .bus(ia));
  fetch_sequencer #(.COUNT_W(2))  dut_b (.clk(clk), .reset(reset), .bus(ib));

  // Reference model state
  logic [31:0] pc_m;
  int          cnt_m;
  bit          mis_pend;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit rdy, input bit be, input bit je, input logic [31:0] ra);
    ia.imem_ready = rdy; ia.branch_enable = be; ia.jump_enable = je; ia.redirect_addr = ra;
    ib.imem_ready = rdy; ib.branch_enable = be; ib.jump_enable = je; ib.redirect_addr = ra;
  endtask

  function automatic logic [31:0] target(input logic [31:0] ra);
`ifdef MISALIGN_TRAP_EN
    return (ra % 4 != 0) ? 32'h0000_0100 : ra;
`else
    return ra - (ra % 4);
`endif
  endfunction

  function automatic bit traps(input logic [31:0] ra);
`ifdef MISALIGN_TRAP_EN
    return (ra % 4 != 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk_counts();
    chk("cnt16", 32'(ia.taken_count), (cnt_m > 65535) ? 32'd65535 : 32'(cnt_m));
    chk("cnt2",  32'(ib.taken_count), (cnt_m > 3) ? 32'd3 : 32'(cnt_m));
  endtask

  task automatic noise(input bit en, input bit rdy);
    if (en) drive($urandom_range(0, 1) == 1 || rdy, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom);
    else    drive(rdy, 1'b0, 1'b0, 32'h0);
  endtask

  // One instruction, entered at a negedge with the DUT in FETCH.
  // k: stall cycles; be/je/ra: WRITEBACK inputs; ex_be: branch driven in EXECUTE only.
  task automatic run_instr(input int k, input bit be, input bit je, input logic [31:0] ra,
                           input bit ex_be, input bit nz);
    for (int s = 0; s <= k; s++) begin
      chk("f_stage", 32'(ia.stage), 32'd0);
      chk("f_req", 32'(ia.imem_req), 32'd1);
      chk("f_addr", ia.imem_addr, pc_m);
      chk("f_ivld", 32'(ia.instr_valid), 32'd0);
      chk("f_mis", 32'(ia.misaligned), (s == 0) ? 32'(mis_pend) : 32'd0);
      chk_counts();
      if (nz) drive(s == k, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
      else    drive(s == k, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
    end
    mis_pend = 1'b0;
    chk("d_stage", 32'(ia.stage), 32'd1);
    chk("d_ivld", 32'(ia.instr_valid), 32'd1);
    chk("d_req", 32'(ia.imem_req), 32'd0);
    chk("d_pc", ia.pc, pc_m);
    noise(nz, 1'b0);
    @(negedge clk);
    chk("e_stage", 32'(ia.stage), 32'd2);
    chk("e_ivld", 32'(ia.instr_valid), 32'd0);
    if (ex_be) drive(1'b1, 1'b1, 1'b0, ra);
    else       noise(nz, 1'b0);
    @(negedge clk);
    chk("w_stage", 32'(ia.stage), 32'd3);
    chk("w_pc", ia.pc, pc_m);
    chk("w_mis", 32'(ia.misaligned), 32'd0);
    drive(nz ? ($urandom_range(0, 1) == 1) : 1'b0, be, je, ra);
    @(negedge clk);
    if (be || je) begin
      cnt_m++;
      pc_m     = target(ra);
      mis_pend = traps(ra);
    end else begin
      pc_m = pc_m + 32'd4;
    end
  endtask

  task automatic model_reset();
    pc_m = 32'h0; cnt_m = 0; mis_pend = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_stage"}, 32'(ia.stage), 32'd0);
    chk({tag, "_pc"}, ia.pc, 32'h0);
    chk({tag, "_req"}, 32'(ia.imem_req), 32'd1);
    chk({tag, "_ivld"}, 32'(ia.instr_valid), 32'd0);
    chk({tag, "_cnt"}, 32'(ia.taken_count), 32'd0);
    chk({tag, "_mis"}, 32'(ia.misaligned), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 32'h40);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;

    // Plain sequential fetches; last one stalls 3 cycles.
    run_instr(0, 0, 0, 32'h0, 0, 0);
    run_instr(0, 0, 0, 32'h0, 0, 0);
    run_instr(0, 0, 0, 32'h0, 0, 0);
    run_instr(3, 0, 0, 32'h0, 0, 0);
    // At 0x10: branch only in EXECUTE is ignored -> 0x14.
    run_instr(0, 0, 0, 32'h40, 1, 0);
    chk("exec_only_pc", pc_m, 32'h14);
    // Redirect back to 0x10, then the taken branch to 0x40.
    run_instr(0, 0, 1, 32'h10, 0, 0);
    run_instr(1, 1, 0, 32'h40, 0, 0);
    // Misaligned target 0x42.
    run_instr(0, 1, 0, 32'h42, 0, 0);
    // Jump to the top word, then wrap to zero; both enables count once.
    run_instr(0, 1, 1, 32'hFFFF_FFFC, 0, 0);
    run_instr(0, 0, 0, 32'h0, 0, 0);
    run_instr(0, 0, 0, 32'h0, 0, 0);
    chk("wrap_pc", ia.pc, 32'h4);

    // Randomized instructions with input noise outside sampling stages.
    for (int i = 0; i < 40; i++) begin
      automatic int          k  = $urandom_range(0, 3);
      automatic bit          be = ($urandom_range(0, 2) == 0);
      automatic bit          je = ($urandom_range(0, 4) == 0);
      automatic logic [31:0] ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
      run_instr(k, be, je, ra, 0, 1);
    end

    // Reset in FETCH with imem_ready=1: async return, ready ignored.
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    #1;
    chk_reset_vals("arst_f");
    @(negedge clk);
    chk_reset_vals("hold_f");
    reset = 1'b0;
    model_reset();
    run_instr(0, 1, 0, 32'h80, 0, 1);
    run_instr(2, 0, 0, 32'h0, 0, 1);

    // Reset mid-instruction (EXECUTE): outstanding instruction abandoned.
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("pre_rst_stage", 32'(ia.stage), 32'd2);
    drive(1'b0, 1'b1, 1'b1, 32'h200);
    reset = 1'b1;
    #1;
    chk_reset_vals("arst_e");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    run_instr(1, 0, 0, 32'h0, 0, 1);
    run_instr(0, 0, 1, 32'h1234_5678, 0, 1);
    run_instr(0, 0, 0, 32'h0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
